memref_stream_reader: RTL and testbench
=======================================

# memref_stream_reader

Initiator for the single-port memref read protocol: drives `addr_en`/`addr_data` into a memref read responder with fixed 1-cycle read latency, collects `rd_data`, and presents the words as a valid/ready stream. It lets kernels and testbenches consume a contiguous array region, such as `A`, `B` or `X` in gesummv, without hand-scheduling addresses. It sits between a memref read port and any stream consumer.

## Interface
- `WIDTH`, 32, data word width
- `SIZE`, 64, memref depth in words
- `ADDR_W`, `$clog2(SIZE)`, address width
- `FIFO_DEPTH`, 4, output buffer depth; must be ≥ 3 for full throughput and ≥ 2 legal

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `t` in 1: start pulse; `base` and `count` sampled on this cycle
- `base` in `ADDR_W`: first word address
- `count` in `ADDR_W+1`: number of words to read
- `busy` out 1: transfer in progress
- `done` out 1: one-cycle completion pulse
- `mem_addr_en` out 1: read request
- `mem_addr_data` out `ADDR_W`: read address
- `mem_rd_data` in `WIDTH`: read data, valid 1 cycle after `mem_addr_en`
- `out_valid` out 1, `out_ready` in 1, `out_data` out `WIDTH`, `out_last` out 1: output stream

## Operation
- **Reset values:** all outputs are 0, the FIFO is empty, the in-flight flag is cleared, and the FSM is in IDLE.
- **FSM states and transitions:**
  - IDLE: on `t`, latch `base`/`count`. If `count==0`, pulse `done` next cycle and stay in IDLE. Otherwise go to ISSUE.
  - ISSUE: issue one read per cycle while `occ + inflight < FIFO_DEPTH`. `occ` is the FIFO occupancy and `inflight` is a 1-bit flag for a read issued the previous cycle. After the `count`-th address, go to DRAIN.
  - DRAIN: wait for the handshake carrying `out_last`. Then go to IDLE and pulse `done`.
- **Addressing:** `addr = base + i·STRIDE`, computed modulo `SIZE`. The address wraps to 0 past `SIZE-1`. `count > SIZE` is legal and re-reads wrapped words.
- **Capture:** the cycle after a request, `mem_rd_data` is pushed into the FIFO unconditionally. The credit rule guarantees the FIFO never overflows.
- **Last marker:** `out_last` is set on the word corresponding to request index `count-1`.
- **`t` while busy:** ignored; the latched parameters are unchanged.
- **Reset mid-operation:** the FIFO is flushed and the in-flight read is discarded; `mem_rd_data` on the next cycle is ignored. No `done` pulse is produced.
- **Stream rule:** `out_valid` and `out_data`/`out_last` remain stable until `out_ready`. The transfer never drops or duplicates a word.

## Timing
- **Start latency:** `t` in cycle 0 → first `mem_addr_en` in cycle 1 → data captured at the end of cycle 2 → `out_valid` in cycle 3 (registered FIFO output).
- **Throughput:** with `out_ready` held high and `FIFO_DEPTH ≥ 3`, one word per cycle.
- **`busy`:** high from cycle 1 through the cycle `done` is high, then low.
- **`done`:**
  - one cycle after the final handshake;
  - or in cycle 1 when `count==0`.
- **Back-to-back starts:** a new `t` is accepted in the cycle `done` is high.

## Configuration
- **`MEMREF_READER_STRIDE_EN` defined:** adds input port `stride` (`ADDR_W` bits, sampled with `t`). Address increments by `stride` modulo `SIZE`. `stride==0` reads `base` repeatedly.
- **Without the macro:** no `stride` port; stride is fixed at 1.

## Structure
- **Package `memref_pkg`:**
  - `MEMREF_RD_LATENCY = 1`;
  - FSM enum `reader_state_t {IDLE, ISSUE, DRAIN}`;
  - typedef for the FIFO entry `{last, data}`.
- **Sub-module `memref_reader_fifo`:**
  - synchronous FIFO of `{last, data}` with registered output and an occupancy output;
  - parameterized by `WIDTH+1` and `FIFO_DEPTH`.

## Test plan
- **Basic read:** `base=0`, `count=8`, `out_ready=1`, memory `mem[i]=i+100` → `out_data` 100..107 in consecutive cycles 3..10; `out_last` on 107; `done` in cycle 11.
- **Wrap:** `base=62`, `count=4`, `SIZE=64` → addresses 62, 63, 0, 1; data order preserved.
- **Backpressure:** `count=8`, `out_ready` toggled 1/0 every cycle →
  - all 8 words delivered in order;
  - `occ + inflight` never exceeds `FIFO_DEPTH`;
  - `mem_addr_en` stalls while the FIFO is full.
- **Zero count:** `count=0` → no `mem_addr_en`; `done` in cycle 1; `busy` high in cycle 1 only.
- **Reset mid-transfer:** `rst` asserted at cycle 5 of an 8-word read →
  - next cycle all outputs are 0 and the FIFO is empty;
  - no `done`;
  - a subsequent `t` reads correctly from a fresh `base`.
- **Stride (`MEMREF_READER_STRIDE_EN`):** `base=1`, `stride=8`, `count=8` → addresses 1, 9, …, 57; then `t` while busy is ignored.

Source files
------------

// File: rtl/memref_pkg.sv
// memref_pkg: shared latency, reader FSM states and FIFO entry layout
package memref_pkg;
  localparam int MEMREF_RD_LATENCY = 1;
  localparam int MEMREF_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} reader_state_t;
  typedef struct packed {
    logic last;
    logic [MEMREF_DATA_W-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/memref_reader_fifo.sv
// memref_reader_fifo: synchronous FIFO with registered output and occupancy count
module memref_reader_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 4,
  parameter int OW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic          valid,
  output logic [W-1:0]  dout,
  output logic [OW-1:0] occ
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign valid = occ != '0;
  assign dout = valid ? mem[rp] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp == PW'(DEPTH - 1) ? '0 : wp + PW'(1);
      end
      if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + PW'(1);
      occ <= occ + OW'(push) - OW'(pop);
    end
  end
endmodule

// File: rtl/memref_stream_reader.sv
// memref_stream_reader: memref read initiator to valid/ready stream; MEMREF_READER_STRIDE_EN adds a stride port
module memref_stream_reader import memref_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SIZE = 64,
  parameter int ADDR_W = $clog2(SIZE),
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
`ifdef MEMREF_READER_STRIDE_EN
  input  logic [ADDR_W-1:0] stride,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_addr_en,
  output logic [ADDR_W-1:0] mem_addr_data,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last
);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0] SZ = (ADDR_W + 1)'(SIZE);
  reader_state_t state;
  logic [ADDR_W-1:0] addr, stride_q, addr_next;
  logic [ADDR_W:0] cnt, idx, addr_sum;
  logic inflight, inflight_last, issue, is_last, pop;
  logic [OW-1:0] occ;
  logic [WIDTH:0] head;
`ifdef MEMREF_READER_STRIDE_EN
  always_ff @(posedge clk) stride_q <= rst ? '0 : (state == IDLE && t) ? stride : stride_q;
`else
  assign stride_q = ADDR_W'(1);
`endif
  // credit: FIFO slots must cover both stored words and the read still in flight
  assign issue = state == ISSUE && (int'(occ) + int'(inflight)) < FIFO_DEPTH;
  assign is_last = idx == cnt - (ADDR_W + 1)'(1);
  assign addr_sum = {1'b0, addr} + {1'b0, stride_q};
  assign addr_next = ADDR_W'(addr_sum >= SZ ? addr_sum - SZ : addr_sum);
  assign mem_addr_en = issue;
  assign mem_addr_data = issue ? addr : '0;
  assign pop = out_valid && out_ready;
  assign out_data = head[WIDTH-1:0];
  assign out_last = head[WIDTH];
  memref_reader_fifo #(.W(WIDTH + 1), .DEPTH(FIFO_DEPTH), .OW(OW)) u_fifo (
    .clk(clk), .rst(rst), .push(inflight), .din({inflight_last, mem_rd_data}),
    .pop(pop), .valid(out_valid), .dout(head), .occ(occ)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      addr <= '0;
      cnt <= '0;
      idx <= '0;
    end else begin
      inflight <= issue;
      inflight_last <= issue && is_last;
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= t;
          if (t) begin
            addr <= base;
            cnt <= count;
            idx <= '0;
            done <= count == '0;
            state <= count == '0 ? IDLE : ISSUE;
          end
        end
        ISSUE: if (issue) begin
          addr <= addr_next;
          idx <= idx + (ADDR_W + 1)'(1);
          if (is_last) state <= DRAIN;
        end
        default: if (pop && out_last) begin
          state <= IDLE;
          done <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memref_stream_reader.sv
// tb_memref_stream_reader: directed scoreboard bench for memref_stream_reader
module tb_memref_stream_reader;
  localparam int W = 32, SZ = 64, AW = 6, D = 4;
  logic clk = 0, rst, t, busy, done, mem_addr_en, out_valid, out_ready, out_last, toggle;
  logic [AW-1:0] base, mem_addr_data, stride_in;
  logic [AW:0] count;
  logic [W-1:0] mem_rd_data = '0, out_data;
  logic [W-1:0] mem [SZ];
  logic [AW-1:0] aq [$];
  logic [W:0] dq [$];
  int vectors = 0, errs = 0, outstanding = 0;
  always #5 clk = ~clk;
  memref_stream_reader dut (
    .clk(clk), .rst(rst), .t(t), .base(base), .count(count),
`ifdef MEMREF_READER_STRIDE_EN
    .stride(stride_in),
`endif
    .busy(busy), .done(done), .mem_addr_en(mem_addr_en), .mem_addr_data(mem_addr_data),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );
  always @(posedge clk) if (mem_addr_en) mem_rd_data <= mem[mem_addr_data];
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) outstanding = 0;
    else begin
      if (mem_addr_en) begin
        outstanding++;
        check("addr_expected", aq.size() != 0, 1);
        if (aq.size() != 0) check("addr", mem_addr_data, aq.pop_front());
        check("credit", outstanding <= D, 1);
      end
      if (out_valid && out_ready) begin
        outstanding--;
        check("word_expected", dq.size() != 0, 1);
        if (dq.size() != 0) check("word", {out_last, out_data}, dq.pop_front());
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle) out_ready = ~out_ready;
  endtask
  task automatic start(input int b, input int c, input int s);
    for (int i = 0; i < c; i++) begin
      int a = (b + i * s) % SZ;
      aq.push_back(AW'(a));
      dq.push_back({i == c - 1, W'(a + 100)});
    end
    base = AW'(b);
    count = (AW + 1)'(c);
    stride_in = AW'(s);
    t = 1;
    tick();
    t = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("done_seen", done, 1);
    check("aq_empty", aq.size(), 0);
    check("dq_empty", dq.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < SZ; i++) mem[i] = W'(i + 100);
    rst = 1; t = 0; base = '0; count = '0; stride_in = '0; out_ready = 1; toggle = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en", mem_addr_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    rst = 0;
    start(0, 8, 1);
    check("b_busy_c1", busy, 1);
    check("b_en_c1", mem_addr_en, 1);
    check("b_valid_c1", out_valid, 0);
    tick();
    check("b_valid_c2", out_valid, 0);
    tick();
    check("b_data_c3", out_data, 100);
    for (int c = 3; c <= 10; c++) begin
      check("b_valid_stream", out_valid, 1);
      check("b_last_stream", out_last, c == 10);
      check("b_done_stream", done, 0);
      tick();
    end
    check("b_done_c11", done, 1);
    check("b_busy_c11", busy, 1);
    start(5, 2, 1);
    check("b2b_en", mem_addr_en, 1);
    check("b2b_busy", busy, 1);
    check("b2b_done", done, 0);
    wait_done();
    tick();
    check("b2b_idle_busy", busy, 0);
    start(62, 4, 1);
    wait_done();
    tick();
    start(0, 0, 1);
    check("z_done_c1", done, 1);
    check("z_busy_c1", busy, 1);
    check("z_en_c1", mem_addr_en, 0);
    tick();
    check("z_done_c2", done, 0);
    check("z_busy_c2", busy, 0);
    check("z_en_c2", mem_addr_en, 0);
    toggle = 1;
    start(10, 8, 1);
    tick();
    tick();
    base = 40; count = 3; t = 1;
    tick();
    t = 0;
    wait_done();
    toggle = 0;
    out_ready = 1;
    tick();
    start(30, 8, 1);
    repeat (4) tick();
    rst = 1;
    aq.delete();
    dq.delete();
    tick();
    rst = 0;
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_en", mem_addr_en, 0);
    check("mr_addr", mem_addr_data, 0);
    check("mr_valid", out_valid, 0);
    check("mr_data", out_data, 0);
    check("mr_last", out_last, 0);
    tick();
    check("mr_valid_late", out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      check("mr_no_done", done, 0);
      tick();
    end
    start(20, 3, 1);
    wait_done();
    tick();
`ifdef MEMREF_READER_STRIDE_EN
    start(1, 8, 8);
    wait_done();
    tick();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
